// File: rtl/tile_painter.sv
// tile_painter: repaints changed grid-tracker cells as 20x20 RGB565 tiles over an 8080-style LCD bus.
// Optional 1-pixel grid outline enabled by defining TILE_PAINTER_OUTLINE_EN.
module tile_painter #(
  parameter int          WR_HALF      = 1,
  parameter logic [15:0] COLOR_EMPTY  = 16'h0000,
  parameter logic [15:0] COLOR_HEAD   = 16'h07E0,
  parameter logic [15:0] COLOR_BODY   = 16'h03E0,
  parameter logic [15:0] COLOR_APPLE  = 16'hF800,
  parameter logic [15:0] COLOR_BORDER = 16'hFFFF,
  parameter logic [15:0] COLOR_GRID   = 16'h4208
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_start,
  input  logic       diff,
  input  logic [2:0] obj_code,
  input  logic [3:0] x,
  input  logic [3:0] y,
  output logic       tracker_en,
  output logic       busy,
  output logic       frame_done,
  output logic       lcd_cs_n,
  output logic       lcd_dcx,
  output logic       lcd_wr_n,
  output logic [7:0] lcd_data
);
  typedef enum logic [2:0] {IDLE, SCAN, WRITE, ADVANCE, DONE} state_t;
  localparam int PW = $clog2(2 * WR_HALF + 1);
  localparam logic [PW-1:0] PH_LOW = PW'(WR_HALF - 1);
  localparam logic [PW-1:0] PH_END = PW'(2 * WR_HALF - 1);
  localparam logic [9:0] LAST_IDX = 10'd810;
  state_t state, nstate;
  logic [PW-1:0] ph;
  logic [9:0] idx, nidx;
  logic [3:0] xr, yr;
  logic [2:0] code_r;
  logic last_r, byte_end, start_byte, ndcx;
  logic [15:0] x0, x1, y0, y1, color, pixel;
  logic [7:0] nbyte;
  always_comb begin
    byte_end = state == WRITE && ph == PH_END;
    start_byte = (state == SCAN && diff) || (byte_end && idx != LAST_IDX);
    nstate = state;
    case (state)
      IDLE:    nstate = frame_start ? SCAN : IDLE;
      SCAN:    nstate = diff ? WRITE : ADVANCE;
      WRITE:   nstate = (byte_end && idx == LAST_IDX) ? ADVANCE : WRITE;
      ADVANCE: nstate = last_r ? DONE : SCAN;
      default: nstate = IDLE;
    endcase
  end
  // Byte stream: 11 address/command bytes, then 400 pixels high byte first.
  always_comb begin
    nidx = state == SCAN ? 10'd0 : idx + 10'd1;
    x0 = 16'(xr) * 16'd20;
    x1 = x0 + 16'd19;
    y0 = 16'(yr) * 16'd20;
    y1 = y0 + 16'd19;
    color = code_r == 3'd1 ? COLOR_HEAD :
            code_r == 3'd2 ? COLOR_BODY :
            code_r == 3'd3 ? COLOR_APPLE :
            code_r == 3'd4 ? COLOR_BORDER : COLOR_EMPTY;
    ndcx = !(nidx == 10'd0 || nidx == 10'd5 || nidx == 10'd10);
    case (nidx)
      10'd0:   nbyte = 8'h2A;
      10'd1:   nbyte = x0[15:8];
      10'd2:   nbyte = x0[7:0];
      10'd3:   nbyte = x1[15:8];
      10'd4:   nbyte = x1[7:0];
      10'd5:   nbyte = 8'h2B;
      10'd6:   nbyte = y0[15:8];
      10'd7:   nbyte = y0[7:0];
      10'd8:   nbyte = y1[15:8];
      10'd9:   nbyte = y1[7:0];
      10'd10:  nbyte = 8'h2C;
      default: nbyte = nidx[0] ? pixel[15:8] : pixel[7:0];
    endcase
  end
`ifdef TILE_PAINTER_OUTLINE_EN
  logic [4:0] col, ncol;
  logic row0, nrow0;
  // Odd byte indices from 11 on start a new pixel; track its column and whether it is in row 0.
  always_comb begin
    ncol = nidx == 10'd11 ? 5'd0 : nidx[0] ? (col == 5'd19 ? 5'd0 : col + 5'd1) : col;
    nrow0 = nidx == 10'd11 ? 1'b1 : nidx[0] ? row0 && col != 5'd19 : row0;
    pixel = (ncol == 5'd0 || nrow0) ? COLOR_GRID : color;
  end
  always_ff @(posedge clk)
    if (rst) begin
      col <= 5'd0;
      row0 <= 1'b1;
    end else if (start_byte) begin
      col <= ncol;
      row0 <= nrow0;
    end
`else
  logic unused_grid;
  assign unused_grid = ^COLOR_GRID;
  assign pixel = color;
`endif
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= nstate;
  always_ff @(posedge clk)
    if (rst) begin
      tracker_en <= 1'b0;
      busy <= 1'b0;
      frame_done <= 1'b0;
      lcd_cs_n <= 1'b1;
      lcd_dcx <= 1'b1;
      lcd_wr_n <= 1'b1;
      lcd_data <= 8'h00;
      ph <= '0;
      idx <= 10'd0;
      xr <= 4'd0;
      yr <= 4'd0;
      code_r <= 3'd0;
      last_r <= 1'b0;
    end else begin
      tracker_en <= nstate == ADVANCE;
      frame_done <= nstate == DONE;
      busy <= nstate == SCAN || nstate == WRITE || nstate == ADVANCE;
      if (state == SCAN) begin
        xr <= x;
        yr <= y;
        code_r <= obj_code;
        last_r <= x == 4'd15 && y == 4'd11;
      end
      if (start_byte) begin
        lcd_data <= nbyte;
        lcd_dcx <= ndcx;
        lcd_wr_n <= 1'b0;
        lcd_cs_n <= 1'b0;
        ph <= '0;
        idx <= nidx;
      end else if (state == WRITE) begin
        ph <= ph + PW'(1);
        if (ph == PH_LOW) lcd_wr_n <= 1'b1;
        if (nstate == ADVANCE) lcd_cs_n <= 1'b1;
      end
    end
endmodule

// File: tb/tb_tile_painter.sv
// tb_tile_painter: directed tests of tile_painter against a behavioural grid-tracker model.
module tb_tile_painter;
  logic clk = 0, rst = 1, frame_start = 0;
  logic diff;
  logic [2:0] obj_code;
  logic [3:0] x, y;
  logic tracker_en, busy, frame_done, lcd_cs_n, lcd_dcx, lcd_wr_n;
  logic [7:0] lcd_data;
  int passed = 0, total = 0;
  int cyc = 0, t_scan = 0, t_done = 0;
  logic done_busy;
  logic [3:0] tx = 0, ty = 0;
  logic [3:0] chg_x = 0, chg_y = 0;
  logic [2:0] chg_code = 0;
  logic chg_on = 0;
  logic [7:0] bytes [0:2047];
  logic dcxs [0:2047];
  int nb = 0, te_cnt = 0, te_adj = 0, low_cnt = 0, cs_cnt = 0, te_first = 0, te_last = 0;
  logic prev_wr = 1, prev_te = 0;
`ifdef TILE_PAINTER_OUTLINE_EN
  localparam bit OUTLINE = 1;
`else
  localparam bit OUTLINE = 0;
`endif

  tile_painter dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .diff(diff), .obj_code(obj_code),
    .x(x), .y(y), .tracker_en(tracker_en), .busy(busy), .frame_done(frame_done),
    .lcd_cs_n(lcd_cs_n), .lcd_dcx(lcd_dcx), .lcd_wr_n(lcd_wr_n), .lcd_data(lcd_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Tracker model: raster walk over 16x12, one changed cell at most.
  always @(posedge clk)
    if (tracker_en) begin
      if (tx == 4'd15) begin
        tx <= 4'd0;
        ty <= ty == 4'd11 ? 4'd0 : ty + 4'd1;
      end else tx <= tx + 4'd1;
    end
  assign x = tx;
  assign y = ty;
  assign diff = chg_on && tx == chg_x && ty == chg_y;
  assign obj_code = chg_code;

  always @(negedge clk) begin
    if (!lcd_wr_n && prev_wr) begin
      if (nb < 2048) begin
        bytes[nb] = lcd_data;
        dcxs[nb] = lcd_dcx;
      end
      nb++;
    end
    prev_wr = lcd_wr_n;
    if (!lcd_wr_n) low_cnt++;
    if (!lcd_cs_n) cs_cnt++;
    if (tracker_en) begin
      if (te_cnt == 0) te_first = cyc;
      te_last = cyc;
      te_cnt++;
      if (prev_te) te_adj++;
    end
    prev_te = tracker_en;
  end

  function automatic logic [15:0] exp_pix(input logic [2:0] c, input int n);
    logic [15:0] k;
    k = c == 3'd1 ? 16'h07E0 : c == 3'd2 ? 16'h03E0 : c == 3'd3 ? 16'hF800 :
        c == 3'd4 ? 16'hFFFF : 16'h0000;
    return (OUTLINE && (n < 20 || n % 20 == 0)) ? 16'h4208 : k;
  endfunction

  function automatic int pix_errs(input logic [2:0] c);
    int e = 0;
    for (int n = 0; n < 400; n++)
      if ({bytes[11 + 2 * n], bytes[12 + 2 * n]} !== exp_pix(c, n) || dcxs[11 + 2 * n] !== 1'b1
          || dcxs[12 + 2 * n] !== 1'b1) e++;
    return e;
  endfunction

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic clr;
    nb = 0; te_cnt = 0; te_adj = 0; low_cnt = 0; cs_cnt = 0;
  endtask

  task automatic setup(input logic [3:0] sx, input logic [3:0] sy, input logic on,
                       input logic [2:0] code);
    tx <= sx;
    ty <= sy;
    chg_on = on;
    chg_x = sx;
    chg_y = sy;
    chg_code = code;
    tick;
    clr;
  endtask

  task automatic start_frame;
    frame_start = 1;
    tick;
    t_scan = cyc;
    frame_start = 0;
  endtask

  task automatic wait_done(input int max);
    t_done = -1;
    for (int i = 0; i < max; i++) begin
      tick;
      if (frame_done) begin
        t_done = cyc;
        done_busy = busy;
        break;
      end
    end
    total++;
    if (t_done < 0) $display("FAIL frame_done timeout after %0d cycles", max);
    else passed++;
  endtask

  task automatic test_reset;
    rst = 1;
    frame_start = 1;
    repeat (3) tick;
    total++; if (busy !== 1'b0) $display("FAIL reset busy: got %b want 0", busy); else passed++;
    total++; if (lcd_cs_n !== 1'b1) $display("FAIL reset cs_n: got %b want 1", lcd_cs_n); else passed++;
    total++; if (lcd_wr_n !== 1'b1) $display("FAIL reset wr_n: got %b want 1", lcd_wr_n); else passed++;
    total++; if (lcd_dcx !== 1'b1) $display("FAIL reset dcx: got %b want 1", lcd_dcx); else passed++;
    total++; if (lcd_data !== 8'h00) $display("FAIL reset data: got %h want 00", lcd_data); else passed++;
    total++; if (tracker_en !== 1'b0) $display("FAIL reset tracker_en: got %b want 0", tracker_en); else passed++;
    total++; if (frame_done !== 1'b0) $display("FAIL reset frame_done: got %b want 0", frame_done); else passed++;
    rst = 0;
    frame_start = 0;
    repeat (3) tick;
    total++; if (busy !== 1'b0) $display("FAIL post-reset idle busy: got %b want 0", busy); else passed++;
  endtask

  task automatic test_no_change;
    setup(4'd0, 4'd0, 1'b0, 3'd0);
    start_frame;
    total++; if (busy !== 1'b1) $display("FAIL nochg busy at scan: got %b want 1", busy); else passed++;
    wait_done(500);
    total++; if (t_done - t_scan !== 384) $display("FAIL nochg frame cycles: got %0d want 384", t_done - t_scan); else passed++;
    total++; if (te_cnt !== 192) $display("FAIL nochg tracker_en pulses: got %0d want 192", te_cnt); else passed++;
    total++; if (te_adj !== 0) $display("FAIL nochg back-to-back tracker_en: got %0d want 0", te_adj); else passed++;
    total++; if (low_cnt !== 0) $display("FAIL nochg wr_n low cycles: got %0d want 0", low_cnt); else passed++;
    total++; if (done_busy !== 1'b0) $display("FAIL nochg busy at done: got %b want 0", done_busy); else passed++;
    tick;
    total++; if (frame_done !== 1'b0) $display("FAIL nochg frame_done width: got %b want 0", frame_done); else passed++;
  endtask

  task automatic test_single_change;
    logic [7:0] hdr [0:10];
    hdr = '{8'h2A, 8'h00, 8'h3C, 8'h00, 8'h4F, 8'h2B, 8'h00, 8'h28, 8'h00, 8'h3B, 8'h2C};
    setup(4'd3, 4'd2, 1'b1, 3'd1);
    start_frame;
    wait_done(3000);
    total++; if (nb !== 811) $display("FAIL single byte count: got %0d want 811", nb); else passed++;
    for (int i = 0; i < 11; i++) begin
      total++;
      if ({dcxs[i], bytes[i]} !== {!(i == 0 || i == 5 || i == 10), hdr[i]})
        $display("FAIL single hdr[%0d]: got dcx=%b %h want dcx=%b %h", i, dcxs[i], bytes[i],
                 !(i == 0 || i == 5 || i == 10), hdr[i]);
      else passed++;
    end
    total++; if (pix_errs(3'd1) !== 0) $display("FAIL single pixels: got %0d bad want 0", pix_errs(3'd1)); else passed++;
    total++; if (low_cnt !== 811) $display("FAIL single wr low cycles: got %0d want 811", low_cnt); else passed++;
    total++; if (cs_cnt !== 1622) $display("FAIL single cs low cycles: got %0d want 1622", cs_cnt); else passed++;
    total++; if (te_first - t_scan !== 1623) $display("FAIL single tracker_en delay: got %0d want 1623", te_first - t_scan); else passed++;
    total++; if (te_cnt !== 157) $display("FAIL single tracker_en pulses: got %0d want 157", te_cnt); else passed++;
    total++; if (t_done - t_scan !== 1936) $display("FAIL single frame cycles: got %0d want 1936", t_done - t_scan); else passed++;
  endtask

  task automatic test_last_cell;
    logic [7:0] hdr [0:10];
    hdr = '{8'h2A, 8'h01, 8'h2C, 8'h01, 8'h3F, 8'h2B, 8'h00, 8'hDC, 8'h00, 8'hEF, 8'h2C};
    setup(4'd15, 4'd11, 1'b1, 3'd4);
    start_frame;
    wait_done(3000);
    total++; if (nb !== 811) $display("FAIL last byte count: got %0d want 811", nb); else passed++;
    for (int i = 0; i < 11; i++) begin
      total++;
      if (bytes[i] !== hdr[i]) $display("FAIL last hdr[%0d]: got %h want %h", i, bytes[i], hdr[i]);
      else passed++;
    end
    total++; if (pix_errs(3'd4) !== 0) $display("FAIL last pixels: got %0d bad want 0", pix_errs(3'd4)); else passed++;
    total++; if (t_done - te_last !== 1) $display("FAIL last done after tracker_en: got %0d want 1", t_done - te_last); else passed++;
    total++; if (t_done - t_scan !== 1624) $display("FAIL last frame cycles: got %0d want 1624", t_done - t_scan); else passed++;
  endtask

  task automatic test_code110;
    setup(4'd14, 4'd11, 1'b1, 3'd6);
    start_frame;
    wait_done(3000);
    total++; if (nb !== 811) $display("FAIL code110 byte count: got %0d want 811", nb); else passed++;
    total++; if (pix_errs(3'd6) !== 0) $display("FAIL code110 pixels: got %0d bad want 0", pix_errs(3'd6)); else passed++;
    total++; if (t_done - t_scan !== 1626) $display("FAIL code110 frame cycles: got %0d want 1626", t_done - t_scan); else passed++;
  endtask

  task automatic test_busy_ignore;
    setup(4'd8, 4'd11, 1'b0, 3'd0);
    start_frame;
    repeat (2) tick;
    total++; if (busy !== 1'b1) $display("FAIL ignore busy mid-frame: got %b want 1", busy); else passed++;
    frame_start = 1;
    repeat (3) tick;
    frame_start = 0;
    wait_done(100);
    total++; if (t_done - t_scan !== 16) $display("FAIL ignore frame cycles: got %0d want 16", t_done - t_scan); else passed++;
    repeat (10) tick;
    total++; if (busy !== 1'b0) $display("FAIL ignore busy after done: got %b want 0", busy); else passed++;
    total++; if (te_cnt !== 8) $display("FAIL ignore tracker_en pulses: got %0d want 8", te_cnt); else passed++;
  endtask

  task automatic test_reset_midstream;
    int n, low;
    bit hit = 0;
    setup(4'd3, 4'd2, 1'b1, 3'd2);
    start_frame;
    for (int i = 0; i < 200 && !hit; i++) begin
      tick;
      hit = nb >= 30;
    end
    total++; if (!hit) $display("FAIL midreset stream reached: got %0d bytes want 30", nb); else passed++;
    rst = 1;
    tick;
    total++; if (lcd_wr_n !== 1'b1) $display("FAIL midreset wr_n: got %b want 1", lcd_wr_n); else passed++;
    total++; if (lcd_cs_n !== 1'b1) $display("FAIL midreset cs_n: got %b want 1", lcd_cs_n); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL midreset busy: got %b want 0", busy); else passed++;
    total++; if (tracker_en !== 1'b0) $display("FAIL midreset tracker_en: got %b want 0", tracker_en); else passed++;
    rst = 0;
    n = nb;
    low = low_cnt;
    repeat (50) tick;
    total++; if (nb !== n) $display("FAIL midreset extra bytes: got %0d want %0d", nb, n); else passed++;
    total++; if (low_cnt !== low) $display("FAIL midreset wr activity: got %0d want %0d", low_cnt, low); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL midreset busy stays low: got %b want 0", busy); else passed++;
  endtask

  initial begin
    test_reset;
    test_no_change;
    test_single_change;
    test_last_cell;
    test_code110;
    test_busy_ignore;
    test_reset_midstream;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/tile_painter.md
Name: tile_painter

Overview:
- Downstream consumer of the grid frame tracker (16x12 cells, 3-bit object codes).
- Walks the tracker one cell at a time by pulsing its enable. For every cell the tracker flags as changed, it repaints a 20x20-pixel tile on a 320x240 RGB565 LCD through an 8080-style 8-bit write bus.
- Unchanged cells are skipped in 2 cycles.

Parameters:
- WR_HALF, 1, clk cycles wr_n is held low, and also held high, per bus byte (>=1).
- COLOR_EMPTY, 16'h0000, RGB565 colour for code 000 and codes 101-111.
- COLOR_HEAD, 16'h07E0, colour for code 001.
- COLOR_BODY, 16'h03E0, colour for code 010.
- COLOR_APPLE, 16'hF800, colour for code 011.
- COLOR_BORDER, 16'hFFFF, colour for code 100.
- COLOR_GRID, 16'h4208, outline colour (optional feature only).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- frame_start  in  1  one-cycle request to scan one full frame
- diff  in  1  tracker: current cell changed (valid only in the sampled cycle)
- obj_code  in  3  tracker: new code of current cell
- x  in  4  tracker: current column, 0..15
- y  in  4  tracker: current row, 0..11
- tracker_en  out  1  one-cycle pulse; advances tracker to the next cell
- busy  out  1  high from the frame_start acceptance edge until frame_done
- frame_done  out  1  one-cycle pulse after cell (15,11) has been processed
- lcd_cs_n  out  1  chip select, active low
- lcd_dcx  out  1  0 = command byte, 1 = data byte
- lcd_wr_n  out  1  write strobe; LCD latches data on its rising edge
- lcd_data  out  8  bus byte

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: tracker_en=0, busy=0, frame_done=0, lcd_cs_n=1, lcd_dcx=1, lcd_wr_n=1, lcd_data=0, FSM in IDLE. The same applies when rst is asserted mid-operation: the bus returns to idle on the next edge and no further byte is issued.
- All outputs are registered.
- IDLE: frame_start=1 -> SCAN and busy=1. frame_start is ignored in every other state.
- SCAN (1 cycle): sample diff, obj_code, x and y in the same cycle; they are not sampled again later.
  - diff=0 -> ADVANCE.
  - diff=1 -> latch code/x/y -> WRITE.
- WRITE: emit 811 bytes in this order:
  - 0x2A with dcx=0, then x0[15:8], x0[7:0], x1[15:8], x1[7:0] with dcx=1.
  - 0x2B with dcx=0, then y0 and y1 bytes in the same format, dcx=1.
  - 0x2C with dcx=0.
  - 400 pixels in raster order (row-major within the tile), each as colour[15:8] then colour[7:0], dcx=1.
- Tile coordinates: x0=x*20, x1=x0+19, y0=y*20, y1=y0+19, all 16-bit unsigned.
- Byte timing: lcd_data and lcd_dcx become valid on the same edge that drives lcd_wr_n low. wr_n stays low WR_HALF cycles, then high WR_HALF cycles. data and dcx are held through the whole 2*WR_HALF window.
- Chip select: lcd_cs_n falls with the first byte of a tile and rises the cycle after that tile's last high phase. It stays high between tiles.
- ADVANCE (1 cycle): tracker_en=1.
  - If the latched/sampled cell was (15,11) -> DONE.
  - Otherwise -> SCAN.
- DONE (1 cycle): frame_done=1, busy=0 -> IDLE.
- Per-cell cost:
  - Unchanged cell: 2 cycles.
  - Changed cell: 811*2*WR_HALF + 2 cycles.
- A no-change frame takes 384 cycles from SCAN entry to DONE.
- Tracker sync is not driven; the frame scan starts at whatever (x,y) the tracker holds and ends at (15,11).

Optional Feature:
- Macro TILE_PAINTER_OUTLINE_EN.
- Defined: pixels in tile row 0 or tile column 0 use COLOR_GRID regardless of code, producing a 1-pixel grid line.
- Undefined: all 400 pixels use the code colour, and COLOR_GRID is unused.
- Byte count and timing are identical in both cases.

Test Plan:
- Reset: hold rst 3 cycles with frame_start=1 -> busy=0, lcd_cs_n=1, lcd_wr_n=1, lcd_dcx=1, lcd_data=0, tracker_en=0.
- No changes: tracker model at (0,0), diff=0 always, pulse frame_start -> 192 tracker_en pulses on alternating cycles, frame_done 384 cycles after SCAN entry, lcd_wr_n never low.
- Single change at (3,2), code 001, WR_HALF=1 -> bytes 2A,00,3C,00,4F,2B,00,28,00,3B,2C then 400x(07,E0) with matching dcx pattern. 1622 cycles of wr activity, then one tracker_en pulse.
- Last cell (15,11), code 100 -> column bytes 01,2C,01,3F, page bytes 00,DC,00,EF, pixels FF,FF. frame_done is asserted one cycle after that cell's tracker_en pulse.
- Code 110 with diff=1 -> pixels 00,00. With TILE_PAINTER_OUTLINE_EN defined, the first 20 pixels and every 20th pixel are 42,08.
- frame_start pulsed while busy -> ignored. rst asserted mid-pixel stream -> lcd_wr_n=1 and lcd_cs_n=1 on the next edge, busy=0, no further bytes issued.
